// File: rtl/lcdg_bus_seq_if.sv
// Command/response handshake bundle between the display controller (master)
// and the lcdg_bus_seq LCD bus sequencer (slave).
interface lcdg_bus_seq_if #(
    parameter int DW = 8
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_di;
    logic          cmd_rd;
    logic [1:0]    cmd_cs;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;

    modport master (
        output cmd_valid, cmd_di, cmd_rd, cmd_cs, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_di, cmd_rd, cmd_cs, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/lcdg_bus_seq.sv
// KS0108-class LCD bus sequencer: power-up LCD reset, then timed setup / EN pulse / hold bus cycles.
// Read cycles with data capture exist only when the LCDG_READ_EN macro is defined.
module lcdg_bus_seq #(
    parameter int DW      = 8,
    parameter int CNT_W   = 8,
    parameter int T_SETUP = 4,
    parameter int T_PW    = 12,
    parameter int T_HOLD  = 4,
    parameter int RST_CYC = 16
) (
    input  logic          clk,
    input  logic          rstn,
    lcdg_bus_seq_if.slave bus,
    output logic [DW-1:0] db_o,
    output logic          db_oe,
    input  logic [DW-1:0] db_i,
    output logic          dori_o,
    output logic          rw_o,
    output logic          en_o,
    output logic          cs1_o,
    output logic          cs2_o,
    output logic          rst_o
);
`ifdef LCDG_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);

    state_t          state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [DW-1:0]   db_r, db_s;
    logic [DW-1:0]   rsp_data_r, rsp_data_s;
    logic [1:0]      cs_r, cs_s;
    logic            dori_r, dori_s;
    logic            rw_r, rw_s;
    logic            en_r, en_s;
    logic            oe_r, oe_s;
    logic            rst_r, rst_s;
    logic            ready_r, ready_s;
    logic            busy_r, busy_s;
    logic            rsp_valid_r, rsp_valid_s;
    logic            rd_s;
    logic            accept_s;
    logic            cnt_done_s;

    // With reads compiled out, cmd_rd is masked so every cycle becomes a write.
    assign rd_s       = bus.cmd_rd & READ_EN;
    assign accept_s   = bus.cmd_valid & ready_r;
    assign cnt_done_s = (cnt_r == CNT_ZERO);

    // Next-state, timing counter and next value of every registered pin/handshake output.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        db_s        = db_r;
        dori_s      = dori_r;
        rw_s        = rw_r;
        en_s        = en_r;
        oe_s        = oe_r;
        cs_s        = cs_r;
        rst_s       = rst_r;
        ready_s     = ready_r;
        busy_s      = busy_r;
        rsp_data_s  = rsp_data_r;
        rsp_valid_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                // INIT counts up from the reset value of 0; bus states count down.
                rst_s   = 1'b0;
                ready_s = 1'b0;
                busy_s  = 1'b1;
                if (cnt_r == RST_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    rst_s   = 1'b1;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (accept_s && (bus.cmd_cs != 2'b00)) begin
                    state_s = ST_SETUP;
                    cnt_s   = LD_SETUP;
                    db_s    = bus.cmd_data;
                    dori_s  = bus.cmd_di;
                    rw_s    = rd_s;
                    oe_s    = ~rd_s;
                    // Two chips must never drive the bus together on a read.
                    cs_s    = (rd_s && (bus.cmd_cs == 2'b11)) ? 2'b01 : bus.cmd_cs;
                    ready_s = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_done_s) begin
                    state_s = ST_PULSE;
                    cnt_s   = LD_PW;
                    en_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_done_s) begin
                    state_s = ST_HOLD;
                    cnt_s   = LD_HOLD;
                    en_s    = 1'b0;
                    if (rw_r) begin
                        rsp_data_s = db_i;
                    end else begin
                        rsp_data_s = rsp_data_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_done_s) begin
                    state_s     = ST_IDLE;
                    cnt_s       = CNT_ZERO;
                    cs_s        = 2'b00;
                    rw_s        = 1'b0;
                    oe_s        = 1'b0;
                    ready_s     = 1'b1;
                    busy_s      = 1'b0;
                    rsp_valid_s = rw_r;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_INIT;
                cnt_s   = CNT_ZERO;
                en_s    = 1'b0;
                cs_s    = 2'b00;
                oe_s    = 1'b0;
                rw_s    = 1'b0;
                rst_s   = 1'b0;
                ready_s = 1'b0;
                busy_s  = 1'b1;
            end
        endcase
    end

    // State, counter and output registers; reset parks the LCD in reset with the bus released.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_INIT;
            cnt_r       <= CNT_ZERO;
            db_r        <= {DW{1'b0}};
            dori_r      <= 1'b0;
            rw_r        <= 1'b0;
            en_r        <= 1'b0;
            oe_r        <= 1'b0;
            cs_r        <= 2'b00;
            rst_r       <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            rsp_data_r  <= {DW{1'b0}};
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            db_r        <= db_s;
            dori_r      <= dori_s;
            rw_r        <= rw_s;
            en_r        <= en_s;
            oe_r        <= oe_s;
            cs_r        <= cs_s;
            rst_r       <= rst_s;
            ready_r     <= ready_s;
            busy_r      <= busy_s;
            rsp_data_r  <= rsp_data_s;
            rsp_valid_r <= rsp_valid_s;
        end
    end

    assign db_o          = db_r;
    assign db_oe         = oe_r;
    assign dori_o        = dori_r;
    assign rw_o          = rw_r;
    assign en_o          = en_r;
    assign cs1_o         = cs_r[0];
    assign cs2_o         = cs_r[1];
    assign rst_o         = rst_r;
    assign bus.cmd_ready = ready_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
endmodule

// File: tb/tb_lcdg_bus_seq.sv
// Self-checking bench for lcdg_bus_seq: vector table, hand-written corner sequences and
// randomized commands checked against a per-cycle timeline model of the bus cycle.
module tb_lcdg_bus_seq;
    localparam int TS  = 4;
    localparam int TPW = 12;
    localparam int TH  = 4;
    localparam int RC  = 16;
    localparam int TOT = TS + TPW + TH;
`ifdef LCDG_READ_EN
    localparam logic RD_EN = 1'b1;
`else
    localparam logic RD_EN = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic [7:0] db_i;
    logic [7:0] db_o;
    logic       db_oe, dori_o, rw_o, en_o, cs1_o, cs2_o, rst_o;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] last_db;
    logic [7:0] last_rsp;
    logic       last_dori;

    lcdg_bus_seq_if #(.DW(8)) bus ();

    lcdg_bus_seq #(
        .DW(8), .CNT_W(8), .T_SETUP(TS), .T_PW(TPW), .T_HOLD(TH), .RST_CYC(RC)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .db_o(db_o), .db_oe(db_oe), .db_i(db_i),
        .dori_o(dori_o), .rw_o(rw_o), .en_o(en_o),
        .cs1_o(cs1_o), .cs2_o(cs2_o), .rst_o(rst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

    typedef struct {
        logic       di;
        logic       rd;
        logic [1:0] cs;
        logic [7:0] data;
        logic [7:0] pdb;
        logic [4:0] exp_snap;   // {cs2, cs1, rw, oe, busy} in the first SETUP cycle
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expects rstn low on entry: checks the reset state, releases reset, checks the INIT phase.
    task automatic init_seq();
        int lows, seq_bad, pins_bad;
        lows = 0; seq_bad = 0; pins_bad = 0;
        @(negedge clk);
        chk("reset_state", 64'({rst_o, en_o, cs1_o, cs2_o, db_oe, rw_o, dori_o, bus.cmd_ready,
                               bus.busy, bus.rsp_valid, db_o, bus.rsp_data}), 64'h0);
        bus.cmd_valid = 1'b1; bus.cmd_cs = 2'b01; bus.cmd_data = 8'hFF;
        bus.cmd_di = 1'b1; bus.cmd_rd = 1'b0;
        rstn = 1'b1;
        for (int k = 0; k <= RC + 2; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_o) lows++;
            if (bus.cmd_ready !== rst_o) seq_bad++;
            if (bus.busy !== ((k > 0) && (k < RC))) seq_bad++;
            if (en_o || cs1_o || cs2_o || db_oe) pins_bad++;
            if (k == RC) bus.cmd_valid = 1'b0;
        end
        chk("rst_low_cycles", 64'(lows), 64'(RC));
        chk("init_ready_busy", 64'(seq_bad), 64'h0);
        chk("init_pins_quiet", 64'(pins_bad), 64'h0);
        last_db = 8'h00; last_dori = 1'b0; last_rsp = 8'h00;
    endtask

    // Issues one command and checks every cycle until idle against the timeline model:
    // pins valid from the accept edge, EN high for samples TS..TS+TPW-1, idle at TOT.
    task automatic do_cmd(input logic di, input logic rd, input logic [1:0] cs,
                          input logic [7:0] data, input logic [7:0] pdb, output logic [4:0] snap);
        logic        rd_e, in_cyc, en_e;
        logic [1:0]  cs_e;
        logic [17:0] exp_v, act_v;
        int          guard, en_cnt;
        rd_e = rd & RD_EN;
        cs_e = (rd_e && (cs == 2'b11)) ? 2'b01 : cs;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_di = di; bus.cmd_rd = rd; bus.cmd_cs = cs; bus.cmd_data = data;
        guard = 0;
        while (!bus.cmd_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 64'(bus.cmd_ready), 64'h1);
            bus.cmd_valid = 1'b0;
            snap = 5'h00;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        snap = {cs2_o, cs1_o, rw_o, db_oe, bus.busy};
        if (cs == 2'b00) begin
            bus.cmd_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                chk($sformatf("drop k=%0d", k),
                    64'({en_o, cs2_o, cs1_o, db_oe, bus.busy, bus.cmd_ready, dori_o, db_o}),
                    64'({5'b00000, 1'b1, last_dori, last_db}));
            end
            return;
        end
        // A different request held during the cycle must be ignored, not queued.
        bus.cmd_di = ~di; bus.cmd_rd = ~rd; bus.cmd_cs = 2'b11; bus.cmd_data = ~data;
        en_cnt = 0;
        for (int k = 0; k <= TOT + 1; k++) begin
            if (k > 0) @(negedge clk);
            in_cyc = (k < TOT);
            en_e   = (k >= TS) && (k < TS + TPW);
            exp_v  = {en_e, (in_cyc ? cs_e : 2'b00), in_cyc & rd_e, in_cyc & ~rd_e, in_cyc, ~in_cyc,
                      ((k == TOT) ? rd_e : 1'b0), di, 1'b1, data};
            act_v  = {en_o, cs2_o, cs1_o, rw_o, db_oe, bus.busy, bus.cmd_ready, bus.rsp_valid,
                      dori_o, rst_o, db_o};
            chk($sformatf("cycle k=%0d", k), 64'(act_v), 64'(exp_v));
            if ((k < TS + TPW) || (k >= TOT))
                chk($sformatf("rsp_data k=%0d", k), 64'(bus.rsp_data),
                    64'(((k >= TOT) && rd_e) ? pdb : last_rsp));
            if (en_o) en_cnt++;
            db_i = (k == TS + TPW - 1) ? pdb : 8'($urandom);
            if (k == TOT) bus.cmd_valid = 1'b0;
        end
        chk("en_width", 64'(en_cnt), 64'(TPW));
        last_db = data; last_dori = di;
        if (rd_e) last_rsp = pdb;
    endtask

    // cmd_valid held high across two writes: accept edges and EN rises are one full
    // busy period plus the accepting cycle apart.
    task automatic t3_back_to_back();
        int   acc, nr;
        int   acc_cyc[2];
        int   rise[2];
        logic rdy_p, v_p, en_p;
        acc = 0; nr = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; rise[0] = 0; rise[1] = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_di = 1'b0; bus.cmd_rd = 1'b0;
        bus.cmd_cs = 2'b10; bus.cmd_data = 8'h11;
        rdy_p = bus.cmd_ready; v_p = 1'b1; en_p = en_o;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rdy_p && v_p && (acc < 2)) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc == 1) bus.cmd_data = 8'h22;
                else bus.cmd_valid = 1'b0;
            end
            if (en_o && !en_p && (nr < 2)) begin
                rise[nr] = cyc;
                nr++;
            end
            rdy_p = bus.cmd_ready; v_p = bus.cmd_valid; en_p = en_o;
        end
        chk("b2b_accepts", 64'(acc), 64'h2);
        chk("b2b_accept_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(TOT + 1));
        chk("b2b_en_pulses", 64'(nr), 64'h2);
        chk("b2b_en_gap", 64'(rise[1] - rise[0]), 64'(TOT + 1));
        chk("b2b_last_data", 64'(db_o), 64'h22);
        last_db = 8'h22; last_dori = 1'b0;
    endtask

    initial begin
        vec_t       vt[6];
        logic [4:0] snap;
        vt[0] = '{di: 1'b1, rd: 1'b0, cs: 2'b01, data: 8'hA5, pdb: 8'h00, exp_snap: 5'b01011};
        vt[1] = '{di: 1'b0, rd: 1'b0, cs: 2'b10, data: 8'h5A, pdb: 8'h00, exp_snap: 5'b10011};
        vt[2] = '{di: 1'b0, rd: 1'b0, cs: 2'b11, data: 8'hC3, pdb: 8'h00, exp_snap: 5'b11011};
`ifdef LCDG_READ_EN
        vt[3] = '{di: 1'b1, rd: 1'b1, cs: 2'b11, data: 8'h00, pdb: 8'h3C, exp_snap: 5'b01101};
        vt[4] = '{di: 1'b0, rd: 1'b1, cs: 2'b10, data: 8'h81, pdb: 8'hE7, exp_snap: 5'b10101};
`else
        vt[3] = '{di: 1'b1, rd: 1'b1, cs: 2'b11, data: 8'h00, pdb: 8'h3C, exp_snap: 5'b11011};
        vt[4] = '{di: 1'b0, rd: 1'b1, cs: 2'b10, data: 8'h81, pdb: 8'hE7, exp_snap: 5'b10011};
`endif
        vt[5] = '{di: 1'b1, rd: 1'b0, cs: 2'b00, data: 8'hFF, pdb: 8'h00, exp_snap: 5'b00000};

        rstn = 1'b0; db_i = 8'h00;
        bus.cmd_valid = 1'b0; bus.cmd_di = 1'b0; bus.cmd_rd = 1'b0;
        bus.cmd_cs = 2'b00; bus.cmd_data = 8'h00;
        last_db = 8'h00; last_dori = 1'b0; last_rsp = 8'h00;
        #12;
        init_seq();

        for (int i = 0; i < 6; i++) begin
            do_cmd(vt[i].di, vt[i].rd, vt[i].cs, vt[i].data, vt[i].pdb, snap);
            chk($sformatf("vec%0d_setup_pins", i), 64'(snap), 64'(vt[i].exp_snap));
        end

        t3_back_to_back();

        for (int i = 0; i < 12; i++) begin
            do_cmd(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom),
                   8'($urandom), snap);
        end

        // Reset asserted in the middle of the EN pulse, away from any clock edge.
        @(negedge clk);
        chk("t6_idle_before", 64'(bus.cmd_ready), 64'h1);
        bus.cmd_valid = 1'b1; bus.cmd_di = 1'b1; bus.cmd_rd = 1'b0;
        bus.cmd_cs = 2'b11; bus.cmd_data = 8'h96;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (TS + 4) @(negedge clk);
        chk("t6_en_high", 64'(en_o), 64'h1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_clear", 64'({en_o, cs1_o, cs2_o, db_oe, rst_o, bus.busy, bus.cmd_ready}), 64'h0);
        init_seq();
        do_cmd(1'b0, 1'b0, 2'b01, 8'h69, 8'h00, snap);
        chk("t6_recovered_pins", 64'(snap), 64'(5'b01011));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
